// File: rtl/alu_ctrl_pkg.sv
// Shared ALU control codes, ALUOp classes, FSM encoding and decode payload for alu_ctrl_seq.
// Codes are CODE_W wide and are zero-extended to CTRL_W at the registered output.
package alu_ctrl_pkg;

  localparam int unsigned CODE_W = 5;

  typedef logic [CODE_W-1:0] code_t;

  localparam code_t ALU_ADD    = 5'h00;
  localparam code_t ALU_SUB    = 5'h01;
  localparam code_t ALU_AND    = 5'h02;
  localparam code_t ALU_OR     = 5'h03;
  localparam code_t ALU_XOR    = 5'h04;
  localparam code_t ALU_SLT    = 5'h05;
  localparam code_t ALU_SLTU   = 5'h06;
  localparam code_t ALU_SLL    = 5'h07;
  localparam code_t ALU_SRL    = 5'h08;
  localparam code_t ALU_SRA    = 5'h09;
  localparam code_t ALU_MUL    = 5'h10;
  localparam code_t ALU_MULH   = 5'h11;
  localparam code_t ALU_MULHSU = 5'h12;
  localparam code_t ALU_MULHU  = 5'h13;
  localparam code_t ALU_DIV    = 5'h14;
  localparam code_t ALU_DIVU   = 5'h15;
  localparam code_t ALU_REM    = 5'h16;
  localparam code_t ALU_REMU   = 5'h17;

  localparam logic [1:0] ALUOP_MEM = 2'b00;
  localparam logic [1:0] ALUOP_BR  = 2'b01;
  localparam logic [1:0] ALUOP_R   = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_MUL_WAIT = 2'd1,
    ST_DIV_WAIT = 2'd2
  } state_t;

  typedef struct packed {
    code_t code;
    logic  is_mdu;
    logic  is_div;
    logic  illegal;
  } dec_t;

  // RV32I integer op selected by funct3; sub/sra qualifiers come from funct7b5.
  function automatic code_t base_code(input logic [2:0] funct3,
                                      input logic       sub_sel,
                                      input logic       sra_sel);
    code_t c;
    c = ALU_ADD;
    case (funct3)
      3'b000: c = sub_sel ? ALU_SUB : ALU_ADD;
      3'b001: c = ALU_SLL;
      3'b010: c = ALU_SLT;
      3'b011: c = ALU_SLTU;
      3'b100: c = ALU_XOR;
      3'b101: c = sra_sel ? ALU_SRA : ALU_SRL;
      3'b110: c = ALU_OR;
      3'b111: c = ALU_AND;
    endcase
    return c;
  endfunction

  // RV32M codes follow funct3 order starting at ALU_MUL.
  function automatic code_t m_code(input logic [2:0] funct3);
    return {2'b10, funct3};
  endfunction

endpackage

// File: rtl/alu_op_decode.sv
// Combinational ALUOp/funct decode into {code, is_mdu, is_div, illegal}.
// RV32M decode is present only when ALU_CTRL_MEXT_EN is defined.
module alu_op_decode
  import alu_ctrl_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic       opb5,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       funct7b0,
  output dec_t       dec
);

  always_comb begin
    dec         = '0;
    dec.code    = ALU_ADD;
    case (alu_op)
      ALUOP_MEM: dec.code = ALU_ADD;
      ALUOP_BR:  dec.code = ALU_SUB;
      ALUOP_R: begin
        if (opb5 & funct7b0) begin
`ifdef ALU_CTRL_MEXT_EN
          if (funct7b5) begin
            dec.illegal = 1'b1;
          end else begin
            dec.code   = m_code(funct3);
            dec.is_mdu = 1'b1;
            dec.is_div = funct3[2];
          end
`else
          dec.illegal = 1'b1;
`endif
        end else begin
          dec.code = base_code(funct3, opb5 & funct7b5, funct7b5);
        end
      end
      default: dec.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_ctrl_seq.sv
// Registered ALU control decode with multi-cycle MDU sequencing and ID back-pressure.
// Macro ALU_CTRL_MEXT_EN enables RV32M decode and the MUL_WAIT/DIV_WAIT sequencer.
module alu_ctrl_seq
  import alu_ctrl_pkg::*;
#(
  parameter int unsigned CTRL_W  = 5,
  parameter int unsigned MUL_LAT = 3,
  parameter int unsigned CNT_W   = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              opb5,
  input  logic [2:0]        funct3,
  input  logic              funct7b5,
  input  logic              funct7b0,
  input  logic [1:0]        ALUOp,
  input  logic              flush,
  input  logic              div_done,
  output logic              out_valid,
  output logic [CTRL_W-1:0] ALUControl,
  output logic              is_mdu,
  output logic              illegal,
  output logic              mdu_start,
  output logic              mdu_kill
);

  dec_t              dec;
  logic              accept;
  logic [CTRL_W-1:0] ctrl_d;
  logic              is_mdu_d;
  logic              illegal_d;
  logic              out_valid_d;
  logic              mdu_start_d;
  logic              mdu_kill_d;

  alu_op_decode u_dec (
    .alu_op   (ALUOp),
    .opb5     (opb5),
    .funct3   (funct3),
    .funct7b5 (funct7b5),
    .funct7b0 (funct7b0),
    .dec      (dec)
  );

  assign accept = in_valid & in_ready;

`ifdef ALU_CTRL_MEXT_EN

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign in_ready = (state_q == ST_IDLE) & ~flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state and next registered outputs; flush overrides completion in the wait states.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ctrl_d      = ALUControl;
    is_mdu_d    = is_mdu;
    illegal_d   = illegal;
    out_valid_d = 1'b0;
    mdu_start_d = 1'b0;
    mdu_kill_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          ctrl_d    = CTRL_W'(dec.code);
          is_mdu_d  = dec.is_mdu;
          illegal_d = dec.illegal;
          if (dec.is_mdu) begin
            mdu_start_d = 1'b1;
            if (dec.is_div) begin
              state_d = ST_DIV_WAIT;
            end else begin
              state_d = ST_MUL_WAIT;
              cnt_d   = CNT_W'(MUL_LAT - 1);
            end
          end else begin
            out_valid_d = 1'b1;
          end
        end
      end
      ST_MUL_WAIT: begin
        if (flush) begin
          state_d    = ST_IDLE;
          mdu_kill_d = 1'b1;
        end else if (cnt_q == '0) begin
          state_d     = ST_IDLE;
          out_valid_d = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_DIV_WAIT: begin
        if (flush) begin
          state_d    = ST_IDLE;
          mdu_kill_d = 1'b1;
        end else if (div_done) begin
          state_d     = ST_IDLE;
          out_valid_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

`else

  localparam int unsigned unused_cfg = MUL_LAT + CNT_W;
  logic unused_sig;
  assign unused_sig = div_done | dec.is_mdu | dec.is_div;

  assign in_ready = ~flush;

  // Single-cycle decode path: every accepted op completes one cycle later.
  always_comb begin
    ctrl_d      = ALUControl;
    is_mdu_d    = 1'b0;
    illegal_d   = illegal;
    out_valid_d = 1'b0;
    mdu_start_d = 1'b0;
    mdu_kill_d  = 1'b0;
    if (accept) begin
      ctrl_d      = CTRL_W'(dec.code);
      illegal_d   = dec.illegal;
      out_valid_d = 1'b1;
    end
  end

`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ALUControl <= CTRL_W'(ALU_ADD);
      is_mdu     <= 1'b0;
      illegal    <= 1'b0;
      out_valid  <= 1'b0;
      mdu_start  <= 1'b0;
      mdu_kill   <= 1'b0;
    end else begin
      ALUControl <= ctrl_d;
      is_mdu     <= is_mdu_d;
      illegal    <= illegal_d;
      out_valid  <= out_valid_d;
      mdu_start  <= mdu_start_d;
      mdu_kill   <= mdu_kill_d;
    end
  end

endmodule
